// File: rtl/adder_pipe_nbit.sv
// Pipelined ripple-carry adder: a WIDTH-bit add split into STAGES chunks, one registered carry hop per stage, valid/ready stream.
// Optional signed-overflow output ovf when ADDER_PIPE_OVF_EN is defined.
module adder_pipe_nbit #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din_one,
    input  logic [WIDTH-1:0] din_two,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef ADDER_PIPE_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = WIDTH / STAGES;

    logic adv;

    // Whole pipe advances together; a blocked output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_cfg_err
        $error("adder_pipe_nbit: WIDTH must be a non-zero multiple of STAGES");
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO  = (k + 1) * CW;
        localparam int REM = WIDTH - LO;

        logic          vin_d;
        logic          cin_d;
        logic [CW-1:0] a_d;
        logic [CW-1:0] b_d;
        logic [CW:0]   add_d;
        logic [LO-1:0] sum_d;

        logic          vld_q;
        logic          carry_q;
        logic [LO-1:0] sum_q;

        // Stage input: external operands for chunk 0, otherwise the previous stage's skewed operands and carry.
        if (k == 0) begin : g_src
            assign vin_d = in_valid;
            assign cin_d = cin;
            assign a_d   = din_one[CW-1:0];
            assign b_d   = din_two[CW-1:0];
            assign sum_d = add_d[CW-1:0];
        end else begin : g_src
            assign vin_d = g_st[k-1].vld_q;
            assign cin_d = g_st[k-1].carry_q;
            assign a_d   = g_st[k-1].g_rem.a_q[CW-1:0];
            assign b_d   = g_st[k-1].g_rem.b_q[CW-1:0];
            assign sum_d = {add_d[CW-1:0], g_st[k-1].sum_q};
        end

        assign add_d = {1'b0, a_d} + {1'b0, b_d} + {{CW{1'b0}}, cin_d};

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
            end else if (adv) begin
                vld_q <= vin_d;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv && vin_d) begin
                carry_q <= add_d[CW];
                sum_q   <= sum_d;
            end
        end

        // Operand chunks not yet added ride along, shrinking by one chunk per stage.
        if (REM > 0) begin : g_rem
            logic [REM-1:0] a_nx;
            logic [REM-1:0] b_nx;
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;

            if (k == 0) begin : g_nx
                assign a_nx = din_one[WIDTH-1:CW];
                assign b_nx = din_two[WIDTH-1:CW];
            end else begin : g_nx
                assign a_nx = g_st[k-1].g_rem.a_q[REM+CW-1:CW];
                assign b_nx = g_st[k-1].g_rem.b_q[REM+CW-1:CW];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && vin_d) begin
                    a_q <= a_nx;
                    b_q <= b_nx;
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].vld_q;
    assign sum       = g_st[STAGES-1].sum_q;
    assign cout      = g_st[STAGES-1].carry_q;

`ifdef ADDER_PIPE_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    assign ovf_d = g_st[STAGES-1].a_d[CW-1] ^ g_st[STAGES-1].b_d[CW-1]
                 ^ g_st[STAGES-1].add_d[CW-1] ^ g_st[STAGES-1].add_d[CW];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv && g_st[STAGES-1].vin_d) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
